// File: rtl/ipv4_rx_parser.sv
// ipv4_rx_parser
//   Takes the receive byte stream from the Ethernet MAC/FIFO and validates the
//   IPv4 header. Checks are version, IHL, Total Length, destination address,
//   protocol list membership and header checksum. Ethernet padding is removed
//   by honouring Total Length. The payload is forwarded with one clock of
//   latency. Every frame ends with exactly one ip_eof or one ip_err pulse.
//
//   Build option: define IPV4_OPTIONS_EN to accept IHL 5..15. Option bytes
//   are checksummed and then discarded. When the macro is not defined, any
//   IHL other than 5 is rejected.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   eth_data_in      frame byte, network order
//   eth_byte_valid   byte strobe (gaps allowed)
//   eth_eof/eth_err  last byte / frame error, qualified by eth_byte_valid
//   ip_data_out      payload byte
//   ip_byte_valid    payload byte strobe
//   ip_eof/ip_err    good-frame end / bad-frame pulse
//   ip_hdr_valid     header accepted pulse
//   ip_proto_idx     index of matched protocol in PROTOCOL_LIST
//   ip_src_addr      source address of accepted header
//   ip_payload_len   Total Length - IHL*4 of accepted header
module ipv4_rx_parser #(
  parameter logic [31:0]                 IP_ADDRESS    = 32'hC0A80101,
  parameter int unsigned                 NUM_PROTOCOLS = 2,
  parameter logic [NUM_PROTOCOLS*8-1:0]  PROTOCOL_LIST = {8'd6, 8'd17},
  parameter int unsigned                 PIDX_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        eth_data_in,
  input  logic              eth_byte_valid,
  input  logic              eth_eof,
  input  logic              eth_err,
  output logic [7:0]        ip_data_out,
  output logic              ip_byte_valid,
  output logic              ip_eof,
  output logic              ip_err,
  output logic              ip_hdr_valid,
  output logic [PIDX_W-1:0] ip_proto_idx,
  output logic [31:0]       ip_src_addr,
  output logic [15:0]       ip_payload_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
`ifdef IPV4_OPTIONS_EN
    S_OPT,
`endif
    S_PAYLOAD,
    S_PAD,
    S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [19:0]        csum_q, csum_d;
  logic [7:0]         ver_ihl_q, ver_ihl_d;
  logic [15:0]        tot_len_q, tot_len_d;
  logic [7:0]         proto_q, proto_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;

  logic [7:0]         data_d;
  logic               bv_d, eof_d, err_d, hv_d;
  logic [PIDX_W-1:0]  pidx_d;
  logic [31:0]        srco_d;
  logic [15:0]        plen_d;

  logic [3:0]         ihl;
  logic [15:0]        hdr_len;
  logic [15:0]        pay_len;
  logic [15:0]        cnt_inc;
  logic               pay_last;
  logic [19:0]        byte_word;
  logic [19:0]        csum_acc;
  logic [16:0]        fold1;
  logic [15:0]        fold2;
  logic               csum_ok;
  logic [31:0]        dst_cmp;
  logic               ihl_ok;
  logic               proto_hit;
  logic [PIDX_W-1:0]  proto_idx;
  logic               hdr_ok;
  logic               hdr_end;

  assign ihl      = ver_ihl_q[3:0];
  assign hdr_len  = {10'd0, ihl, 2'b00};
  assign pay_len  = tot_len_q - hdr_len;
  assign cnt_inc  = cnt_q + 16'd1;
  assign pay_last = (cnt_inc == tot_len_q);

  // Even byte index is the high half of a 16-bit word, odd index the low half.
  assign byte_word = cnt_q[0] ? {12'd0, eth_data_in} : {4'd0, eth_data_in, 8'd0};
  assign csum_acc  = csum_q + byte_word;
  assign fold1     = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
  assign fold2     = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_ok   = (fold2 == 16'hFFFF);

  // On byte 19 the last destination byte is still on the input bus.
  assign dst_cmp = (state_q == S_HDR) ? {dst_q[23:0], eth_data_in} : dst_q;

`ifdef IPV4_OPTIONS_EN
  assign ihl_ok = (ihl >= 4'd5);
`else
  assign ihl_ok = (ihl == 4'd5);
`endif

  always_comb begin
    proto_hit = 1'b0;
    proto_idx = '0;
    for (int unsigned k = 0; k < NUM_PROTOCOLS; k++) begin
      if (!proto_hit && (proto_q == PROTOCOL_LIST[8*k +: 8])) begin
        proto_hit = 1'b1;
        proto_idx = PIDX_W'(k);
      end
    end
  end

  assign hdr_ok = (ver_ihl_q[7:4] == 4'd4) && ihl_ok && (tot_len_q >= hdr_len) &&
                  (dst_cmp == IP_ADDRESS) && proto_hit && csum_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    ver_ihl_d = ver_ihl_q;
    tot_len_d = tot_len_q;
    proto_d   = proto_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = ip_data_out;
    bv_d      = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    hv_d      = 1'b0;
    pidx_d    = ip_proto_idx;
    srco_d    = ip_src_addr;
    plen_d    = ip_payload_len;
    hdr_end   = 1'b0;

    if (eth_byte_valid) begin
      cnt_d = cnt_inc;
      case (state_q)
        S_IDLE: begin
          csum_d    = byte_word;
          ver_ihl_d = eth_data_in;
          // A one-byte frame ending here returns to IDLE so the next byte
          // still starts a new frame.
          if (eth_err || eth_eof) begin
            err_d   = 1'b1;
            state_d = eth_eof ? S_IDLE : S_DROP;
          end else begin
            state_d = S_HDR;
          end
        end

        S_HDR: begin
          csum_d = csum_acc;
          if (cnt_q == 16'd2) tot_len_d[15:8] = eth_data_in;
          if (cnt_q == 16'd3) tot_len_d[7:0]  = eth_data_in;
          if (cnt_q == 16'd9) proto_d         = eth_data_in;
          if (cnt_q inside {[16'd12:16'd15]}) src_d = {src_q[23:0], eth_data_in};
          if (cnt_q inside {[16'd16:16'd19]}) dst_d = {dst_q[23:0], eth_data_in};
          if (eth_err || eth_eof) begin
            err_d   = 1'b1;
            state_d = eth_eof ? S_IDLE : S_DROP;
          end else if (cnt_q == 16'd19) begin
`ifdef IPV4_OPTIONS_EN
            if (ihl > 4'd5) state_d = S_OPT;
            else            hdr_end = 1'b1;
`else
            hdr_end = 1'b1;
`endif
          end
        end

`ifdef IPV4_OPTIONS_EN
        S_OPT: begin
          csum_d = csum_acc;
          if (eth_err || eth_eof) begin
            err_d   = 1'b1;
            state_d = eth_eof ? S_IDLE : S_DROP;
          end else if (cnt_q == hdr_len - 16'd1) begin
            hdr_end = 1'b1;
          end
        end
`endif

        S_PAYLOAD: begin
          if (eth_err) begin
            err_d   = 1'b1;
            state_d = eth_eof ? S_IDLE : S_DROP;
          end else begin
            bv_d   = 1'b1;
            data_d = eth_data_in;
            if (eth_eof) begin
              eof_d   = pay_last;
              err_d   = !pay_last;
              state_d = S_IDLE;
            end else if (pay_last) begin
              state_d = S_PAD;
            end
          end
        end

        S_PAD: begin
          if (eth_err) begin
            err_d   = 1'b1;
            state_d = eth_eof ? S_IDLE : S_DROP;
          end else if (eth_eof) begin
            eof_d   = 1'b1;
            state_d = S_IDLE;
          end
        end

        S_DROP: begin
          if (eth_eof) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase

      if (hdr_end) begin
        if (hdr_ok) begin
          hv_d    = 1'b1;
          pidx_d  = proto_idx;
          srco_d  = src_q;
          plen_d  = pay_len;
          state_d = (pay_len == 16'd0) ? S_PAD : S_PAYLOAD;
        end else begin
          err_d   = 1'b1;
          state_d = S_DROP;
        end
      end

      if (state_d == S_IDLE) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      csum_q         <= '0;
      ver_ihl_q      <= '0;
      tot_len_q      <= '0;
      proto_q        <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      ip_data_out    <= '0;
      ip_byte_valid  <= 1'b0;
      ip_eof         <= 1'b0;
      ip_err         <= 1'b0;
      ip_hdr_valid   <= 1'b0;
      ip_proto_idx   <= '0;
      ip_src_addr    <= '0;
      ip_payload_len <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      csum_q         <= csum_d;
      ver_ihl_q      <= ver_ihl_d;
      tot_len_q      <= tot_len_d;
      proto_q        <= proto_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      ip_data_out    <= data_d;
      ip_byte_valid  <= bv_d;
      ip_eof         <= eof_d;
      ip_err         <= err_d;
      ip_hdr_valid   <= hv_d;
      ip_proto_idx   <= pidx_d;
      ip_src_addr    <= srco_d;
      ip_payload_len <= plen_d;
    end
  end

endmodule

// File: tb/tb_ipv4_rx_parser.sv
// Directed bench for ipv4_rx_parser. The protocol list is {17, 6}, so
// entry 0 = 6 (TCP) and entry 1 = 17 (UDP).
module tb_ipv4_rx_parser;

  localparam logic [31:0] DUT_IP = 32'hC0A80101;
  localparam logic [31:0] SRC_IP = 32'h0A000001;

  logic        clk;
  logic        rst_n;
  logic [7:0]  eth_data_in;
  logic        eth_byte_valid;
  logic        eth_eof;
  logic        eth_err;
  logic [7:0]  ip_data_out;
  logic        ip_byte_valid;
  logic        ip_eof;
  logic        ip_err;
  logic        ip_hdr_valid;
  logic [2:0]  ip_proto_idx;
  logic [31:0] ip_src_addr;
  logic [15:0] ip_payload_len;

  ipv4_rx_parser #(
    .IP_ADDRESS    (DUT_IP),
    .NUM_PROTOCOLS (2),
    .PROTOCOL_LIST ({8'd17, 8'd6}),
    .PIDX_W        (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .eth_data_in    (eth_data_in),
    .eth_byte_valid (eth_byte_valid),
    .eth_eof        (eth_eof),
    .eth_err        (eth_err),
    .ip_data_out    (ip_data_out),
    .ip_byte_valid  (ip_byte_valid),
    .ip_eof         (ip_eof),
    .ip_err         (ip_err),
    .ip_hdr_valid   (ip_hdr_valid),
    .ip_proto_idx   (ip_proto_idx),
    .ip_src_addr    (ip_src_addr),
    .ip_payload_len (ip_payload_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus frame under construction and the payload expected from it.
  logic [7:0] fb[$];
  bit         fe[$];
  bit         fr[$];
  logic [7:0] expq[$];

  // Observed behaviour.
  logic [7:0] rxq[$];
  logic [2:0] hp[$];
  int mon_eof, mon_err, mon_hdr, mon_eof_wb;
  int eof_cyc, eof_drv_cyc;

  always @(posedge clk) begin
    #1;
    if (ip_byte_valid) rxq.push_back(ip_data_out);
    if (ip_eof) begin
      mon_eof++;
      eof_cyc = cyc;
      if (ip_byte_valid) mon_eof_wb++;
    end
    if (ip_err) mon_err++;
    if (ip_hdr_valid) begin
      mon_hdr++;
      hp.push_back(ip_proto_idx);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void clear();
    fb.delete(); fe.delete(); fr.delete(); expq.delete();
    rxq.delete(); hp.delete();
    mon_eof = 0; mon_err = 0; mon_hdr = 0; mon_eof_wb = 0;
    eof_cyc = -1; eof_drv_cyc = -100;
  endfunction

  function automatic void push(input logic [7:0] b);
    fb.push_back(b); fe.push_back(1'b0); fr.push_back(1'b0);
  endfunction

  // corrupt: 0 none, 1 invert checksum byte 10, 2 Total Length +5 after checksum.
  function automatic void add_hdr(input logic [3:0] ver, input logic [3:0] ihl,
                                  input logic [15:0] tl, input logic [7:0] proto,
                                  input logic [31:0] dst, input int corrupt);
    logic [7:0]  h[60];
    logic [31:0] s;
    logic [15:0] c;
    int n;
    n = int'(ihl) * 4;
    for (int i = 0; i < 60; i++) h[i] = 8'h00;
    h[0] = {ver, ihl}; h[2] = tl[15:8]; h[3] = tl[7:0];
    h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h40; h[8] = 8'h40; h[9] = proto;
    h[12] = SRC_IP[31:24]; h[13] = SRC_IP[23:16]; h[14] = SRC_IP[15:8]; h[15] = SRC_IP[7:0];
    h[16] = dst[31:24];    h[17] = dst[23:16];    h[18] = dst[15:8];    h[19] = dst[7:0];
    for (int i = 20; i < n; i++) h[i] = (i % 4 == 3) ? 8'h00 : 8'h01;
    s = 0;
    for (int i = 0; i < n; i += 2) s = s + {16'd0, h[i], h[i+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    c = ~s[15:0];
    h[10] = c[15:8]; h[11] = c[7:0];
    if (corrupt == 1) h[10] = ~h[10];
    if (corrupt == 2) {h[2], h[3]} = tl + 16'd5;
    for (int i = 0; i < n; i++) push(h[i]);
  endfunction

  function automatic void add_pay(input int n, input logic [7:0] seed, input int n_exp);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i * 13);
      push(b);
      if (i < n_exp) expq.push_back(b);
    end
  endfunction

  function automatic void end_frame(input bit err);
    fe[fe.size()-1] = 1'b1;
    fr[fr.size()-1] = err;
  endfunction

  task automatic send();
    for (int i = 0; i < fb.size(); i++) begin
      if (i % 9 == 5) begin
        @(negedge clk);
        eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
      end
      @(negedge clk);
      eth_data_in = fb[i]; eth_byte_valid = 1'b1; eth_eof = fe[i]; eth_err = fr[i];
      if (fe[i]) eof_drv_cyc = cyc;
    end
    @(negedge clk);
    eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input string t, input int e_eof, input int e_err, input int e_hdr);
    int mism;
    check({t, "_nbytes"}, rxq.size(), expq.size());
    check({t, "_eof"}, mon_eof, e_eof);
    check({t, "_err"}, mon_err, e_err);
    check({t, "_hdr"}, mon_hdr, e_hdr);
    mism = 0;
    for (int i = 0; i < expq.size(); i++)
      if (i >= rxq.size() || rxq[i] !== expq[i]) mism++;
    check({t, "_data"}, mism, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; eth_data_in = 8'h00; eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
    clear();
    repeat (3) @(negedge clk);
    check("rst_pulses", {28'd0, ip_byte_valid, ip_eof, ip_err, ip_hdr_valid}, 0);
    check("rst_data", ip_data_out, 0);
    check("rst_pidx", ip_proto_idx, 0);
    check("rst_src", ip_src_addr, 0);
    check("rst_len", ip_payload_len, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Valid UDP, 20-byte payload, eof on the last payload byte.
    clear();
    add_hdr(4'd4, 4'd5, 16'd40, 8'd17, DUT_IP, 0); add_pay(20, 8'h10, 20); end_frame(1'b0);
    send();
    verify("udp", 1, 0, 1);
    check("udp_eof_with_byte", mon_eof_wb, 1);
    check("udp_pidx", ip_proto_idx, 1);
    check("udp_len", ip_payload_len, 20);
    check("udp_src", ip_src_addr, 32'h0A000001);

    // Total Length 30 with 46 bytes after the header: 36 bytes of padding.
    clear();
    add_hdr(4'd4, 4'd5, 16'd30, 8'd17, DUT_IP, 0); add_pay(46, 8'h50, 10); end_frame(1'b0);
    send();
    verify("pad", 1, 0, 1);
    check("pad_eof_with_byte", mon_eof_wb, 0);
    check("pad_eof_latency", eof_cyc, eof_drv_cyc + 1);
    check("pad_len", ip_payload_len, 10);

    // Header rejects.
    for (int k = 0; k < 5; k++) begin
      clear();
      case (k)
        0: add_hdr(4'd3, 4'd5, 16'd40, 8'd17, DUT_IP, 0);
        1: add_hdr(4'd4, 4'd5, 16'd40, 8'd1, DUT_IP, 0);
        2: add_hdr(4'd4, 4'd5, 16'd40, 8'd17, 32'hC0A80102, 0);
        3: add_hdr(4'd4, 4'd5, 16'd40, 8'd17, DUT_IP, 1);
        default: add_hdr(4'd4, 4'd5, 16'd40, 8'd17, DUT_IP, 2);
      endcase
      add_pay(20, 8'h30, 0); end_frame(1'b0);
      send();
      verify($sformatf("rej%0d", k), 0, 1, 0);
    end
    check("rej_len_held", ip_payload_len, 10);

    // eth_err with eth_eof on the last of 55 payload bytes.
    clear();
    add_hdr(4'd4, 4'd5, 16'd75, 8'd6, DUT_IP, 0); add_pay(55, 8'h77, 54); end_frame(1'b1);
    send();
    verify("crc", 0, 1, 1);
    check("crc_pidx", ip_proto_idx, 0);
    check("crc_len", ip_payload_len, 55);

    // IHL 6 with four option bytes, 8-byte payload.
    clear();
`ifdef IPV4_OPTIONS_EN
    add_hdr(4'd4, 4'd6, 16'd32, 8'd17, DUT_IP, 0); add_pay(8, 8'hA0, 8); end_frame(1'b0);
    send();
    verify("opt", 1, 0, 1);
    check("opt_len", ip_payload_len, 8);
`else
    add_hdr(4'd4, 4'd6, 16'd32, 8'd17, DUT_IP, 0); add_pay(8, 8'hA0, 0); end_frame(1'b0);
    send();
    verify("opt", 0, 1, 0);
`endif

    // Back-to-back: TCP frame then UDP frame with no idle cycle between.
    clear();
    add_hdr(4'd4, 4'd5, 16'd24, 8'd6, DUT_IP, 0);  add_pay(4, 8'h11, 4); end_frame(1'b0);
    add_hdr(4'd4, 4'd5, 16'd26, 8'd17, DUT_IP, 0); add_pay(6, 8'h22, 6); end_frame(1'b0);
    send();
    verify("b2b", 2, 0, 2);
    if (hp.size() == 2) begin
      check("b2b_pidx0", hp[0], 0);
      check("b2b_pidx1", hp[1], 1);
    end
    check("b2b_len", ip_payload_len, 6);

    // Reset after 10 payload bytes, then a clean frame.
    clear();
    add_hdr(4'd4, 4'd5, 16'd40, 8'd17, DUT_IP, 0); add_pay(10, 8'h40, 10);
    send();
    verify("pre_rst", 0, 0, 1);
    clear();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_pulses", rxq.size() + mon_eof + mon_err + mon_hdr, 0);
    check("rst2_src", ip_src_addr, 0);
    check("rst2_len", ip_payload_len, 0);
    check("rst2_data", ip_data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clear();
    add_hdr(4'd4, 4'd5, 16'd36, 8'd17, DUT_IP, 0); add_pay(16, 8'h05, 16); end_frame(1'b0);
    send();
    verify("post_rst", 1, 0, 1);
    check("post_rst_len", ip_payload_len, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
